// File: rtl/clb_cfg_pkg.sv
// Shared types and parameter checks for the multi-lane configuration chain.
// Build option: CLB_CCFF_PARITY_EN adds commit-time parity checking.
package clb_cfg_pkg;

   typedef enum logic [1:0] {
      EMPTY,
      LOADING,
      FULL,
      COMMIT
   } state_t;

   function automatic bit cfg_legal(int cfg_w, int n_lanes);
      return (n_lanes > 0) && (cfg_w >= n_lanes) && (cfg_w % n_lanes == 0);
   endfunction

endpackage

// File: rtl/clb_ccff_shadow_ctrl_if.sv
// Chain and commit-handshake bundle between the loader and the tile front end.
// Build option: CLB_CCFF_PARITY_EN adds the ccff_par_in signal.
interface clb_ccff_shadow_ctrl_if #(
   parameter int CFG_W   = 64,
   parameter int N_LANES = 1
);
   localparam int DEPTH = CFG_W / N_LANES;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic               ccff_en;
   logic [N_LANES-1:0] ccff_head;
   logic [N_LANES-1:0] ccff_tail;
   logic               commit_req;
   logic               commit_ack;
   logic [CFG_W-1:0]   cfg_out;
   logic               cfg_valid;
   logic [CNT_W-1:0]   beat_cnt;
   logic               overrun;
   logic               cfg_err;
`ifdef CLB_CCFF_PARITY_EN
   logic               ccff_par_in;
`endif

   modport master (
      output ccff_en, ccff_head, commit_req,
`ifdef CLB_CCFF_PARITY_EN
      output ccff_par_in,
`endif
      input  ccff_tail, commit_ack, cfg_out, cfg_valid,
      input  beat_cnt, overrun, cfg_err
   );

   modport slave (
      input  ccff_en, ccff_head, commit_req,
`ifdef CLB_CCFF_PARITY_EN
      input  ccff_par_in,
`endif
      output ccff_tail, commit_ack, cfg_out, cfg_valid,
      output beat_cnt, overrun, cfg_err
   );

endinterface

// File: rtl/clb_ccff_shadow_sr.sv
// Shadow shift register, saturating beat counter and running parity.
// Build option: CLB_CCFF_PARITY_EN enables the parity accumulator.
module clb_ccff_shadow_sr #(
   parameter int CFG_W   = 64,
   parameter int N_LANES = 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  shift,
   input  logic                                  clr,
   input  logic [N_LANES-1:0]                    head,
   output logic [CFG_W-1:0]                      shadow,
   output logic [$clog2(CFG_W/N_LANES+1)-1:0]    beat_cnt
`ifdef CLB_CCFF_PARITY_EN
   ,
   output logic                                  par
`endif
);
   import clb_cfg_pkg::*;

   localparam int DEPTH = CFG_W / N_LANES;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [CFG_W-1:0] shadow_nxt;

   // A single-beat chain has no lower slice to keep
   if (DEPTH == 1) begin : g_one
      assign shadow_nxt = head;
   end else begin : g_many
      assign shadow_nxt = {shadow[CFG_W-N_LANES-1:0], head};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
      end else if (shift) begin
         shadow <= shadow_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
      end else if (clr) begin
         beat_cnt <= '0;
      end else if (shift && beat_cnt != CNT_W'(DEPTH)) begin
         beat_cnt <= beat_cnt + 1'b1;
      end
   end

`ifdef CLB_CCFF_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par <= 1'b0;
      end else if (clr) begin
         par <= 1'b0;
      end else if (shift) begin
         par <= par ^ (^head);
      end
   end
`endif

endmodule

// File: rtl/clb_ccff_shadow_ctrl.sv
// Double-buffered multi-lane configuration chain with atomic commit.
// Build option: CLB_CCFF_PARITY_EN gates the commit on a parity match.
module clb_ccff_shadow_ctrl #(
   parameter int CFG_W   = 64,
   parameter int N_LANES = 1
) (
   input  logic                  prog_clk,
   input  logic                  prog_rst_n,
   clb_ccff_shadow_ctrl_if.slave bus
);
   import clb_cfg_pkg::*;

   localparam int DEPTH = CFG_W / N_LANES;
   localparam int CNT_W = $clog2(DEPTH + 1);

   if (!cfg_legal(CFG_W, N_LANES)) begin : g_bad_cfg
      $error("CFG_W must be a non-zero multiple of N_LANES");
   end

   state_t           state;
   state_t           state_nxt;
   logic [CFG_W-1:0] shadow;
   logic [CNT_W-1:0] beat_cnt;
   logic [CFG_W-1:0] cfg_q;
   logic             valid_q;
   logic             ack_q;
   logic             ovr_q;
   logic             commit_go;
   logic             shift;
   logic             clr;
   logic             par_ok;

   // Commit has priority over a coincident beat in FULL
   assign commit_go = (state == FULL) && bus.commit_req;
   assign shift     = bus.ccff_en && (state != COMMIT) && !commit_go;
   assign clr       = (state == COMMIT);

`ifdef CLB_CCFF_PARITY_EN
   logic par;
   logic err_q;

   assign par_ok = (par == bus.ccff_par_in);

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         err_q <= 1'b0;
      end else if (commit_go) begin
         err_q <= !par_ok;
      end
   end

   assign bus.cfg_err = err_q;
`else
   assign par_ok      = 1'b1;
   assign bus.cfg_err = 1'b0;
`endif

   clb_ccff_shadow_sr #(
      .CFG_W   (CFG_W),
      .N_LANES (N_LANES)
   ) u_sr (
      .clk      (prog_clk),
      .rst_n    (prog_rst_n),
      .shift    (shift),
      .clr      (clr),
      .head     (bus.ccff_head),
      .shadow   (shadow),
      .beat_cnt (beat_cnt)
`ifdef CLB_CCFF_PARITY_EN
      ,
      .par      (par)
`endif
   );

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         EMPTY: begin
            if (shift) state_nxt = (DEPTH == 1) ? FULL : LOADING;
         end
         LOADING: begin
            if (shift && beat_cnt == CNT_W'(DEPTH - 1)) state_nxt = FULL;
         end
         FULL: begin
            if (bus.commit_req) state_nxt = COMMIT;
         end
         COMMIT: begin
            state_nxt = EMPTY;
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         cfg_q   <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ack_q <= commit_go;
         if (commit_go && par_ok) begin
            cfg_q   <= shadow;
            valid_q <= 1'b1;
         end
         if (clr) begin
            ovr_q <= 1'b0;
         end else if (shift && state == FULL) begin
            ovr_q <= 1'b1;
         end
      end
   end

   assign bus.ccff_tail  = shadow[CFG_W-1 -: N_LANES];
   assign bus.commit_ack = ack_q;
   assign bus.cfg_out    = cfg_q;
   assign bus.cfg_valid  = valid_q;
   assign bus.beat_cnt   = beat_cnt;
   assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_clb_ccff_shadow_ctrl.sv
// Directed bench for the shadow chain controller, CFG_W=8 and N_LANES=2.
// Build option: CLB_CCFF_PARITY_EN adds the parity scenario.
module tb_clb_ccff_shadow_ctrl;

   logic prog_clk = 1'b0;
   logic prog_rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 prog_clk = ~prog_clk;

   clb_ccff_shadow_ctrl_if #(.CFG_W(8), .N_LANES(2)) bus ();

   clb_ccff_shadow_ctrl #(
      .CFG_W   (8),
      .N_LANES (2)
   ) dut (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .bus        (bus)
   );

   task automatic idle_inputs();
      bus.ccff_en    = 1'b0;
      bus.ccff_head  = 2'b00;
      bus.commit_req = 1'b0;
`ifdef CLB_CCFF_PARITY_EN
      bus.ccff_par_in = 1'b0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      prog_rst_n = 1'b0;
      repeat (2) @(negedge prog_clk);
      prog_rst_n = 1'b1;
      @(negedge prog_clk);
   endtask

   task automatic beat(input logic [1:0] h);
      bus.ccff_en   = 1'b1;
      bus.ccff_head = h;
      @(negedge prog_clk);
      bus.ccff_en   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.cfg_out !== 8'h00 || bus.cfg_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_cfg got %h/%b want 00/0", bus.cfg_out, bus.cfg_valid);
      end
      checks++;
      if (bus.beat_cnt !== 3'd0 || bus.commit_ack !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctl got cnt=%0d ack=%b ovr=%b want 0/0/0",
                  bus.beat_cnt, bus.commit_ack, bus.overrun);
      end
      checks++;
      if (bus.ccff_tail !== 2'b00 || bus.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_tail got %b/%b want 00/0", bus.ccff_tail, bus.cfg_err);
      end
   endtask

   task automatic test_commit();
      do_reset();
      beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
      checks++;
      if (bus.beat_cnt !== 3'd4 || bus.cfg_valid !== 1'b0) begin
         errors++;
         $display("FAIL commit_pre got cnt=%0d valid=%b want 4/0", bus.beat_cnt, bus.cfg_valid);
      end
      bus.commit_req = 1'b1;
      @(negedge prog_clk);
      bus.commit_req = 1'b0;
      checks++;
      if (bus.commit_ack !== 1'b1 || bus.cfg_out !== 8'h6C || bus.cfg_valid !== 1'b1) begin
         errors++;
         $display("FAIL commit_ack got ack=%b cfg=%h valid=%b want 1/6c/1",
                  bus.commit_ack, bus.cfg_out, bus.cfg_valid);
      end
      @(negedge prog_clk);
      checks++;
      if (bus.commit_ack !== 1'b0 || bus.beat_cnt !== 3'd0 || bus.cfg_out !== 8'h6C) begin
         errors++;
         $display("FAIL commit_post got ack=%b cnt=%0d cfg=%h want 0/0/6c",
                  bus.commit_ack, bus.beat_cnt, bus.cfg_out);
      end
   endtask

   task automatic test_early_req();
      do_reset();
      beat(2'b11); beat(2'b00); beat(2'b01);
      bus.commit_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge prog_clk);
         checks++;
         if (bus.commit_ack !== 1'b0 || bus.cfg_out !== 8'h00) begin
            errors++;
            $display("FAIL early_req cyc%0d got ack=%b cfg=%h want 0/00",
                     i, bus.commit_ack, bus.cfg_out);
         end
      end
      bus.commit_req = 1'b0;
      beat(2'b10);
      bus.commit_req = 1'b1;
      @(negedge prog_clk);
      bus.commit_req = 1'b0;
      checks++;
      if (bus.commit_ack !== 1'b1 || bus.cfg_out !== 8'hC6) begin
         errors++;
         $display("FAIL early_commit got ack=%b cfg=%h want 1/c6", bus.commit_ack, bus.cfg_out);
      end
      @(negedge prog_clk);
   endtask

   task automatic test_overrun();
      do_reset();
      beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
      checks++;
      if (bus.ccff_tail !== 2'b01 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_4th got tail=%b ovr=%b want 01/0", bus.ccff_tail, bus.overrun);
      end
      beat(2'b11);
      checks++;
      if (bus.ccff_tail !== 2'b10 || bus.overrun !== 1'b1 || bus.beat_cnt !== 3'd4) begin
         errors++;
         $display("FAIL ovr_5th got tail=%b ovr=%b cnt=%0d want 10/1/4",
                  bus.ccff_tail, bus.overrun, bus.beat_cnt);
      end
      bus.commit_req = 1'b1;
      @(negedge prog_clk);
      bus.commit_req = 1'b0;
      checks++;
      if (bus.cfg_out !== 8'hB3 || bus.commit_ack !== 1'b1) begin
         errors++;
         $display("FAIL ovr_commit got cfg=%h ack=%b want b3/1", bus.cfg_out, bus.commit_ack);
      end
      @(negedge prog_clk);
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_clear got %b want 0", bus.overrun);
      end
   endtask

   task automatic test_commit_wins();
      do_reset();
      beat(2'b10); beat(2'b01); beat(2'b11); beat(2'b01);
      bus.commit_req = 1'b1;
      bus.ccff_en    = 1'b1;
      bus.ccff_head  = 2'b11;
      @(negedge prog_clk);
      bus.commit_req = 1'b0;
      checks++;
      if (bus.cfg_out !== 8'h9D || bus.commit_ack !== 1'b1 || bus.ccff_tail !== 2'b10) begin
         errors++;
         $display("FAIL wins_commit got cfg=%h ack=%b tail=%b want 9d/1/10",
                  bus.cfg_out, bus.commit_ack, bus.ccff_tail);
      end
      @(negedge prog_clk);
      bus.ccff_en = 1'b0;
      checks++;
      if (bus.beat_cnt !== 3'd0 || bus.ccff_tail !== 2'b10 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL wins_post got cnt=%0d tail=%b ovr=%b want 0/10/0",
                  bus.beat_cnt, bus.ccff_tail, bus.overrun);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
      bus.commit_req = 1'b1;
      @(negedge prog_clk);
      bus.commit_req = 1'b0;
      @(negedge prog_clk);
      beat(2'b11); beat(2'b11);
      checks++;
      if (bus.cfg_out !== 8'h6C || bus.beat_cnt !== 3'd2) begin
         errors++;
         $display("FAIL arst_pre got cfg=%h cnt=%0d want 6c/2", bus.cfg_out, bus.beat_cnt);
      end
      #2 prog_rst_n = 1'b0;
      #1;
      checks++;
      if (bus.cfg_out !== 8'h00 || bus.cfg_valid !== 1'b0 || bus.beat_cnt !== 3'd0) begin
         errors++;
         $display("FAIL arst_cfg got cfg=%h valid=%b cnt=%0d want 00/0/0",
                  bus.cfg_out, bus.cfg_valid, bus.beat_cnt);
      end
      checks++;
      if (bus.ccff_tail !== 2'b00 || bus.commit_ack !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL arst_ctl got tail=%b ack=%b ovr=%b want 00/0/0",
                  bus.ccff_tail, bus.commit_ack, bus.overrun);
      end
      @(negedge prog_clk);
      prog_rst_n = 1'b1;
      bus.commit_req = 1'b1;
      repeat (2) @(negedge prog_clk);
      bus.commit_req = 1'b0;
      checks++;
      if (bus.commit_ack !== 1'b0 || bus.cfg_out !== 8'h00) begin
         errors++;
         $display("FAIL arst_empty got ack=%b cfg=%h want 0/00", bus.commit_ack, bus.cfg_out);
      end
   endtask

`ifdef CLB_CCFF_PARITY_EN
   task automatic test_parity();
      do_reset();
      beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
      bus.ccff_par_in = 1'b1;
      bus.commit_req  = 1'b1;
      @(negedge prog_clk);
      bus.commit_req  = 1'b0;
      checks++;
      if (bus.commit_ack !== 1'b1 || bus.cfg_out !== 8'h00 || bus.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL par_bad got ack=%b cfg=%h err=%b want 1/00/1",
                  bus.commit_ack, bus.cfg_out, bus.cfg_err);
      end
      @(negedge prog_clk);
      checks++;
      if (bus.cfg_err !== 1'b1 || bus.beat_cnt !== 3'd0) begin
         errors++;
         $display("FAIL par_sticky got err=%b cnt=%0d want 1/0", bus.cfg_err, bus.beat_cnt);
      end
      beat(2'b01); beat(2'b10); beat(2'b11); beat(2'b00);
      bus.ccff_par_in = 1'b0;
      bus.commit_req  = 1'b1;
      @(negedge prog_clk);
      bus.commit_req  = 1'b0;
      checks++;
      if (bus.commit_ack !== 1'b1 || bus.cfg_out !== 8'h6C || bus.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL par_good got ack=%b cfg=%h err=%b want 1/6c/0",
                  bus.commit_ack, bus.cfg_out, bus.cfg_err);
      end
      @(negedge prog_clk);
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_commit();
      test_early_req();
      test_overrun();
      test_commit_wins();
      test_async_reset();
`ifdef CLB_CCFF_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clb_ccff_shadow_ctrl.md
Name: clb_ccff_shadow_ctrl

Overview:
Parametrised configuration-chain front end for a logic tile. It shifts configuration bits in over N_LANES parallel chains into a shadow register and forwards chain data at the tail. On a commit handshake it transfers the shadow contents atomically to the active configuration bus, so the tile logic never sees partial configuration. It replaces the fixed single-bit ccff_head/ccff_tail chain with a multi-lane, double-buffered chain.

Parameters:
CFG_W, 64, total configuration bits per tile; must be a multiple of N_LANES.
N_LANES, 1, parallel chain lanes shifted per beat.
DEPTH (localparam), CFG_W/N_LANES, beats needed to fill the shadow register.
CNT_W (localparam), $clog2(DEPTH+1), width of the beat counter.

Ports:
prog_clk  in  1  configuration clock; only clock in the block.
prog_rst_n  in  1  asynchronous, active-low reset.
ccff_en  in  1  shift enable; one beat per cycle while high.
ccff_head  in  N_LANES  chain input data.
ccff_tail  out  N_LANES  chain output, equal to shadow[CFG_W-1 -: N_LANES].
commit_req  in  1  level request to transfer shadow to active.
commit_ack  out  1  one-cycle pulse, asserted when a commit executes.
cfg_out  out  CFG_W  active configuration bus driving the tile.
cfg_valid  out  1  high once at least one commit has been accepted since reset.
beat_cnt  out  CNT_W  beats shifted since the last commit, saturating at DEPTH.
overrun  out  1  sticky; set when a beat is shifted while the block is FULL.

Behaviour:
- Reset (async assert, sync release): shadow, cfg_out, beat_cnt, cfg_valid, commit_ack, overrun and cfg_err are all 0; state is EMPTY. Reset in the middle of a load discards everything, including cfg_out.
- Shift: when ccff_en is high and the state is not COMMIT, shadow <= {shadow[CFG_W-N_LANES-1:0], ccff_head}. beat_cnt increments and saturates at DEPTH.
- FSM states:
  - EMPTY (beat_cnt=0): a shift moves to LOADING, or to FULL if DEPTH=1.
  - LOADING: goes to FULL on the beat that makes beat_cnt equal DEPTH.
  - FULL: a shift with ccff_en keeps the state FULL, passes data through to ccff_tail, and sets overrun. A commit_req moves to COMMIT.
  - COMMIT: lasts one cycle, then goes to EMPTY.
- Commit timing: when commit_req is sampled high in FULL at edge t, then at edge t+1 cfg_out <= shadow, commit_ack=1, cfg_valid=1, and the state is COMMIT. At edge t+2, commit_ack=0, beat_cnt=0, overrun=0, and the state is EMPTY.
- commit_req in EMPTY or LOADING is ignored: no ack, and cfg_out is unchanged.
- commit_req and ccff_en high in the same FULL cycle: the commit wins and the shift is suppressed that cycle.
- ccff_en during COMMIT is ignored.
- The shadow is not cleared by a commit; ccff_tail keeps presenting the old contents until new beats arrive.
- ccff_tail is purely registered (taken from shadow), with no combinational path from ccff_head.

Optional Feature:
Macro CLB_CCFF_PARITY_EN.
- With the macro: an extra input ccff_par_in (1 bit) is added. A running XOR of all bits shifted in since the last EMPTY is kept and compared to ccff_par_in at the commit_req sample.
  - Mismatch: cfg_out is NOT updated, commit_ack still pulses, cfg_err (output, 1 bit) is set and stays sticky until the next matching commit. The state still returns to EMPTY.
  - Match: normal commit, and cfg_err is cleared.
- Without the macro: ccff_par_in is absent and cfg_err is tied to 0.

Decomposition:
- Package clb_cfg_pkg holds the FSM state enum (EMPTY, LOADING, FULL, COMMIT) and the parameter legality checks (CFG_W % N_LANES == 0).
- Sub-module clb_ccff_shadow_sr holds the shadow shift register, the saturating beat counter and the parity accumulator.
- The top level holds the FSM, the active register and the handshake.

Test Plan:
1. CFG_W=8, N_LANES=2: reset, shift beats 01,10,11,00, then commit_req -> cfg_out=8'h6C and commit_ack high for exactly one cycle, one cycle after the request; cfg_valid=1, beat_cnt returns to 0.
2. Three beats, then commit_req held 2 cycles -> no ack and cfg_out stays 0; fourth beat plus commit -> ack and cfg_out updated.
3. Five beats 01,10,11,00,11 -> overrun=1; after the fourth beat ccff_tail=01, after the fifth ccff_tail=10; the next commit clears overrun and gives cfg_out=8'hB3.
4. In FULL, commit_req and ccff_en high in the same cycle -> commit executes, cfg_out = pre-shift shadow, beat_cnt=0, and the beat is discarded.
5. After a good commit (cfg_out=8'h6C), 2 beats, then prog_rst_n pulsed low mid-cycle -> all outputs 0 immediately (asynchronous), state EMPTY.
6. With CLB_CCFF_PARITY_EN: beats giving XOR=0 and ccff_par_in=1 -> ack pulses, cfg_out unchanged, cfg_err=1. Reload with matching parity -> cfg_out updated, cfg_err=0.
